// File: rtl/proc_fetch_pkg.sv
// rtl/proc_fetch_pkg.sv - fetch sequencer states, opcode constants and word helpers
package proc_fetch_pkg;

   localparam int DATA_W = 9;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F_WAIT,
      S_F_CAP,
      S_I_WAIT,
      S_I_CAP,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } fetch_state_t;

   function automatic logic is_imm(input logic [DATA_W-1:0] word, input logic [2:0] op);
      return word[DATA_W-1 -: 3] == op;
   endfunction

endpackage

// File: rtl/instr_fetch_seq_mem_lat_timer.sv
// rtl/instr_fetch_seq_mem_lat_timer.sv - loadable down-counter timing ROM read latency
module mem_lat_timer (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       dec,
   output logic       expired
);

   logic [1:0] count;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= 2'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != 2'd0) begin
         count <= count - 2'd1;
      end
   end

   // The wait state leaves on the cycle the count reads 1, so data is valid at capture.
   assign expired = (count == 2'd1);

endmodule

// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - handshaken ROM-to-processor instruction fetch sequencer
// Optional PROG_WRAP_EN: continue from address 0 after the last program word instead of halting.
module instr_fetch_seq
   import proc_fetch_pkg::*;
#(
   parameter int         ADDR_W   = 5,
   parameter int         PROG_LEN = 32,
   parameter int         MEM_LAT  = 1,
   parameter logic [2:0] IMM_OP   = OP_MVI
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Done,
   input  logic [DATA_W-1:0] MemData,
   output logic [ADDR_W-1:0] Addr,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   output logic              Busy,
   output logic              Halted,
   output logic [7:0]        InstrCount
);

   localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(PROG_LEN - 1);
   localparam logic [1:0]        LAT      = 2'(MEM_LAT);
`ifdef PROG_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   fetch_state_t      state;
   logic [DATA_W-1:0] instr;
   logic [DATA_W-1:0] imm;
   logic              last_word;
   logic              tmr_expired;
   logic              tmr_load;
   logic              tmr_dec;
   logic              start_ok;
   logic              done_ok;
   logic              at_end;
   logic              halt_now;

   // last_word remembers that the instruction came from the final address even after
   // an immediate fetch has moved Addr past it.
   always_comb begin
      start_ok = (state == S_IDLE || state == S_HALT) && Start;
      done_ok  = (state == S_ISSUE || state == S_EXEC) && Done;
      at_end   = last_word || (Addr == END_ADDR);
      halt_now = done_ok && at_end && !WRAP;
      tmr_load = start_ok || (state == S_F_CAP && is_imm(MemData, IMM_OP)) || (done_ok && !halt_now);
      tmr_dec  = (state == S_F_WAIT) || (state == S_I_WAIT);
   end

   mem_lat_timer u_timer (
      .clk      (Clock),
      .resetn   (Resetn),
      .load     (tmr_load),
      .load_val (LAT),
      .dec      (tmr_dec),
      .expired  (tmr_expired)
   );

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state      <= S_IDLE;
         Addr       <= '0;
         DIN        <= '0;
         Run        <= 1'b0;
         Busy       <= 1'b0;
         Halted     <= 1'b0;
         InstrCount <= 8'd0;
         instr      <= '0;
         imm        <= '0;
         last_word  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (Start) begin
                  Addr       <= '0;
                  InstrCount <= 8'd0;
                  Halted     <= 1'b0;
                  Busy       <= 1'b1;
                  state      <= S_F_WAIT;
               end
            end
            S_F_WAIT: if (tmr_expired) state <= S_F_CAP;
            S_F_CAP: begin
               instr     <= MemData;
               last_word <= (Addr == END_ADDR);
               if (is_imm(MemData, IMM_OP)) begin
                  Addr  <= Addr + 1'b1;
                  state <= S_I_WAIT;
               end else begin
                  DIN   <= MemData;
                  Run   <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_I_WAIT: if (tmr_expired) state <= S_I_CAP;
            S_I_CAP: begin
               imm   <= MemData;
               DIN   <= instr;
               Run   <= 1'b1;
               state <= S_ISSUE;
            end
            S_ISSUE, S_EXEC: begin
               Run <= 1'b0;
               if (Done) begin
                  InstrCount <= InstrCount + 8'd1;
                  if (halt_now) begin
                     Halted <= 1'b1;
                     Busy   <= 1'b0;
                     state  <= S_HALT;
                  end else begin
                     Addr  <= at_end ? '0 : Addr + 1'b1;
                     state <= S_F_WAIT;
                  end
               end else if (state == S_ISSUE) begin
                  DIN   <= is_imm(instr, IMM_OP) ? imm : instr;
                  state <= S_EXEC;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - directed bench with a cycle-arithmetic fetch model
module tb_instr_fetch_seq;

   localparam int PL = 4;
   localparam int L  = 1;

   logic       clk;
   logic       Resetn, Start, Done, Start2, Done2;
   logic [8:0] MemData, MemData2, DIN, DIN2;
   logic [4:0] Addr, Addr2;
   logic       Run, Busy, Halted, Run2, Busy2, Halted2;
   logic [7:0] InstrCount, InstrCount2;

   logic [8:0] rom [0:31];
   logic [8:0] p1;
   logic [8:0] q [0:2];

   int total = 0;
   int bad   = 0;
   bit armed = 0;

   instr_fetch_seq #(.ADDR_W(5), .PROG_LEN(PL), .MEM_LAT(L)) dut (
      .Clock(clk), .Resetn(Resetn), .Start(Start), .Done(Done), .MemData(MemData),
      .Addr(Addr), .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted), .InstrCount(InstrCount)
   );

   instr_fetch_seq #(.ADDR_W(5), .PROG_LEN(PL), .MEM_LAT(3)) dut3 (
      .Clock(clk), .Resetn(Resetn), .Start(Start2), .Done(Done2), .MemData(MemData2),
      .Addr(Addr2), .DIN(DIN2), .Run(Run2), .Busy(Busy2), .Halted(Halted2), .InstrCount(InstrCount2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM with 1-cycle and 3-cycle read latency
   always @(posedge clk) begin
      p1   <= rom[Addr];
      q[0] <= rom[Addr2];
      q[1] <= q[0];
      q[2] <= q[1];
   end
   assign MemData  = p1;
   assign MemData2 = q[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: event arithmetic on the edges at which fetches start and Done is accepted
   int         n_edge = 0;
   int         m_mode = 0;
   int         m_a = 0, m_fe = 0, m_run = 0, m_cnt = 0, m_hold_addr = 0;
   bit         m_imm = 0;
   logic [8:0] m_ins = '0, m_immw = '0, m_dhold = '0;

   task automatic m_fetch(input int a);
      m_a    = a;
      m_fe   = n_edge;
      m_ins  = rom[a];
      m_imm  = (m_ins[8:6] == 3'b001);
      m_immw = rom[(a + 1) % 32];
      m_run  = n_edge + L + 1 + (m_imm ? L + 1 : 0);
   endtask

   always @(posedge clk) begin
      bit last;
      n_edge++;
      if (!Resetn) begin
         m_mode = 0; m_cnt = 0; m_hold_addr = 0; m_a = 0; m_imm = 0;
         m_fe = 0; m_run = 0; m_dhold = '0;
      end else if (m_mode != 1) begin
         if (Start) begin
            m_mode = 1;
            m_cnt  = 0;
            m_fetch(0);
         end
      end else if (Done && n_edge > m_run) begin
         m_cnt   = (m_cnt + 1) % 256;
         m_dhold = (n_edge == m_run + 1) ? m_ins : (m_imm ? m_immw : m_ins);
         last    = (m_a == PL - 1) || (m_imm && ((m_a + 1) % 32) == PL - 1);
         if (last) begin
            m_mode      = 2;
            m_hold_addr = m_imm ? (m_a + 1) % 32 : m_a;
         end else begin
            m_fetch((m_imm ? m_a + 2 : m_a + 1) % 32);
         end
      end
   end

   always @(negedge clk) begin
      int         e_addr;
      logic [8:0] e_din;
      if (armed) begin
         if (m_mode == 1) e_addr = (m_imm && n_edge >= m_fe + L + 1) ? (m_a + 1) % 32 : m_a;
         else             e_addr = m_hold_addr;
         if (m_mode == 1 && n_edge >= m_run)
            e_din = (n_edge == m_run) ? m_ins : (m_imm ? m_immw : m_ins);
         else
            e_din = m_dhold;
         chk("m_addr",   32'(Addr),       32'(e_addr));
         chk("m_din",    32'(DIN),        32'(e_din));
         chk("m_run",    32'(Run),        32'(m_mode == 1 && n_edge == m_run));
         chk("m_busy",   32'(Busy),       32'(m_mode == 1));
         chk("m_halted", 32'(Halted),     32'(m_mode == 2));
         chk("m_count",  32'(InstrCount), 32'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run();
      int k = 0;
      while (!Run && k < 40) begin
         step();
         k++;
      end
      if (!Run) begin
         total++;
         bad++;
         $display("FAIL run_timeout act=0 exp=1 t=%0t", $time);
      end
   endtask

   task automatic run_instr(input int delay, input bit noise);
      wait_run();
      for (int i = 0; i < delay; i++) begin
         Start = noise;
         step();
      end
      Start = 1'b0;
      Done  = 1'b1;
      step();
      Done  = 1'b0;
   endtask

   initial begin
      Resetn = 1'b0; Start = 1'b0; Done = 1'b0; Start2 = 1'b0; Done2 = 1'b0;
      for (int i = 0; i < 32; i++) rom[i] = 9'h000;
      rom[0] = 9'h00A; rom[1] = 9'h0D3; rom[2] = 9'h091; rom[3] = 9'h00C;
      step();
      armed = 1;
      step();
      Resetn = 1'b1;
      chk("rst_addr", 32'(Addr), 0);
      chk("rst_din", 32'(DIN), 0);
      chk("rst_run", 32'(Run), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_halted", 32'(Halted), 0);
      chk("rst_count", 32'(InstrCount), 0);

      // plain instruction; slow ROM instance runs alongside with Done pulses in F_WAIT
      Start = 1'b1; Start2 = 1'b1;
      step();
      Start = 1'b0; Start2 = 1'b0; Done2 = 1'b1;
      chk("t1_busy", 32'(Busy), 1);
      step();
      chk("t1_run_early", 32'(Run), 0);
      step();
      chk("t1_run", 32'(Run), 1);
      chk("t1_din", 32'(DIN), 32'h00A);
      chk("t1_addr", 32'(Addr), 0);
      step();
      Done2 = 1'b0;
      chk("lat3_run_early", 32'(Run2), 0);
      step();
      chk("lat3_run", 32'(Run2), 1);
      chk("lat3_din", 32'(DIN2), 32'h00A);
      chk("lat3_count", 32'(InstrCount2), 0);
      chk("lat3_addr", 32'(Addr2), 0);
      Done = 1'b1;
      step();
      Done = 1'b0;
      chk("t1_addr_next", 32'(Addr), 1);
      chk("t1_count", 32'(InstrCount), 1);

      // rest of program, Done in ISSUE, with Start noise while busy
      run_instr(0, 1'b0);
      run_instr(2, 1'b1);
      run_instr(1, 1'b0);
      chk("halt_halted", 32'(Halted), 1);
      chk("halt_count", 32'(InstrCount), 4);
      chk("halt_addr", 32'(Addr), 3);
      chk("halt_busy", 32'(Busy), 0);

      // restart from HALT while Done is also high
      Start = 1'b1; Done = 1'b1;
      step();
      Start = 1'b0; Done = 1'b0;
      chk("restart_addr", 32'(Addr), 0);
      chk("restart_count", 32'(InstrCount), 0);
      chk("restart_halted", 32'(Halted), 0);

      // reset during EXEC
      wait_run();
      step();
      step();
      Resetn = 1'b0;
      step();
      Resetn = 1'b1;
      chk("exrst_addr", 32'(Addr), 0);
      chk("exrst_din", 32'(DIN), 0);
      chk("exrst_run", 32'(Run), 0);
      chk("exrst_busy", 32'(Busy), 0);
      chk("exrst_halted", 32'(Halted), 0);
      Done = 1'b1;
      step();
      Done = 1'b0;
      chk("idle_done_busy", 32'(Busy), 0);
      chk("idle_done_count", 32'(InstrCount), 0);

      // immediate loads, including one at the last address
      rom[0] = 9'h040; rom[1] = 9'h1C5; rom[2] = 9'h00A; rom[3] = 9'h040; rom[4] = 9'h155;
      Start = 1'b1;
      step();
      Start = 1'b0;
      step(); step(); step();
      chk("imm_run_early", 32'(Run), 0);
      step();
      chk("imm_run", 32'(Run), 1);
      chk("imm_din_op", 32'(DIN), 32'h040);
      chk("imm_addr", 32'(Addr), 1);
      step();
      chk("imm_din_data", 32'(DIN), 32'h1C5);
      chk("imm_run_off", 32'(Run), 0);
      Done = 1'b1;
      step();
      Done = 1'b0;
      chk("imm_next_addr", 32'(Addr), 2);
      chk("imm_count", 32'(InstrCount), 1);
      run_instr(2, 1'b0);
      run_instr(2, 1'b0);
      chk("lastimm_halted", 32'(Halted), 1);
      chk("lastimm_addr", 32'(Addr), 4);
      chk("lastimm_count", 32'(InstrCount), 3);
      chk("lastimm_din", 32'(DIN), 32'h155);

      step(); step();
      armed = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
